// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the audio synth path.
//   PERIOD_W    : width of a tone-generator period, in clk cycles
//   NOTE_W      : width of a MIDI note number
//   CLK_HZ      : system clock frequency
//   va_state_t  : voice allocator request FSM states
//   note_period : equal-tempered period of a MIDI note in clk cycles, rounded
//                 to nearest (A4 = note 69 = 440 Hz); used at elaboration
//                 time only, to fill the period ROM
// -----------------------------------------------------------------------------
package synth_pkg;

    localparam int PERIOD_W = 26;
    localparam int NOTE_W   = 7;
    localparam int CLK_HZ   = 48_000_000;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        COMMIT
    } va_state_t;

    function automatic logic [PERIOD_W-1:0] note_period(input int n);
        real freq_hz;
        freq_hz = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
        return PERIOD_W'($rtoi(real'(CLK_HZ) / freq_hz + 0.5));
    endfunction

endpackage

// File: rtl/note_period_rom.sv
// -----------------------------------------------------------------------------
// note_period_rom
// 128 x 26 synchronous ROM mapping a MIDI note number to the period of its
// equal-tempered pitch in clk cycles. One cycle of read latency.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the output reg)
//   addr       : MIDI note number 0..127
//   data       : registered period for the note presented on the prior edge
// -----------------------------------------------------------------------------
module note_period_rom
    import synth_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NOTE_W-1:0]   addr,
    output logic [PERIOD_W-1:0] data
);

    localparam int DEPTH = 1 << NOTE_W;

    logic [PERIOD_W-1:0] rom [DEPTH];

    // Every entry is an elaboration-time constant, so the table folds to logic.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [PERIOD_W-1:0] VAL = note_period(i);
        assign rom[i] = VAL;
    end

    // NOTE: only the output register takes reset; the table itself is constant
    // and needs none (a RAM-style array would not be reset either).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Polyphonic voice controller. Takes note-on / note-off requests over a
// valid/ready handshake and assigns notes to NVOICES sawtooth generators,
// driving each generator's enable and period. Each request takes three
// cycles: IDLE (accept) -> LOOKUP (ROM read, voice selection) -> COMMIT.
//
// Parameters:
//   NVOICES : number of tone generators managed (2..8)
//   AGE_W   : width of the per-voice saturating age counter
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : request present
//   req_ready    : request accepted at the next edge when valid
//   req_on       : 1 = note-on, 0 = note-off
//   req_note     : MIDI note number
//   voice_en     : per-voice generator enable
//   voice_period : packed periods, voice i at [26i+25:26i]
//   active_count : number of enabled voices
//   dropped      : one-cycle pulse when a note-on is discarded
// Build option:
//   VOICE_STEAL_EN : when defined, a note-on with every voice busy steals the
//                    oldest voice (lowest index on ties) instead of being
//                    dropped.
// -----------------------------------------------------------------------------
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NVOICES = 4,
    parameter int AGE_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_on,
    input  logic [NOTE_W-1:0]             req_note,
    output logic [NVOICES-1:0]            voice_en,
    output logic [NVOICES*PERIOD_W-1:0]   voice_period,
    output logic [3:0]                    active_count,
    output logic                          dropped
);

    localparam int IDX_W = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    // Request FSM and latched request
    va_state_t           state;
    logic                cur_on;
    logic [NOTE_W-1:0]   cur_note;

    // Selection results registered at the end of LOOKUP
    logic                pick_valid_q;
    idx_t                pick_idx_q;
    logic [NVOICES-1:0]  off_mask_q;

    // Per-voice state
    logic [NVOICES-1:0]  en_q;
    logic [NOTE_W-1:0]   note_q   [NVOICES];
    logic [PERIOD_W-1:0] period_q [NVOICES];
    logic [AGE_W-1:0]    age_q    [NVOICES];

    logic [PERIOD_W-1:0] rom_data;

    // The ROM is addressed by the latched note, so its output is valid from
    // LOOKUP's closing edge onwards, in time for COMMIT.
    note_period_rom u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (cur_note),
        .data  (rom_data)
    );

    // ---------------------------------------------------------------- lookup
    logic [NVOICES-1:0] match_mask;
    logic               hit_any;
    logic               free_any;
    idx_t               hit_idx;
    idx_t               free_idx;
    logic               pick_valid;
    idx_t               pick_idx;

    // NOTE: every signal driven from always_comb gets a default before any
    // conditional assignment, so no path can leave it holding (no latch).
    always_comb begin
        match_mask = '0;
        hit_idx    = '0;
        free_idx   = '0;
        // Descending scan: the last write is the lowest matching index.
        for (int i = NVOICES - 1; i >= 0; i--) begin
            match_mask[i] = en_q[i] && (note_q[i] == cur_note);
            if (match_mask[i]) hit_idx  = idx_t'(i);
            if (!en_q[i])      free_idx = idx_t'(i);
        end
        hit_any  = |match_mask;
        free_any = ~&en_q;
    end

`ifdef VOICE_STEAL_EN
    idx_t             oldest_idx;
    logic [AGE_W-1:0] oldest_age;

    // Strict greater-than keeps the lowest index on equal ages.
    always_comb begin
        oldest_idx = '0;
        oldest_age = age_q[0];
        for (int i = 1; i < NVOICES; i++) begin
            if (age_q[i] > oldest_age) begin
                oldest_age = age_q[i];
                oldest_idx = idx_t'(i);
            end
        end
    end
`endif

    // Note-on target: retrigger, else first free voice, else full-bank rule.
    always_comb begin
        pick_valid = 1'b1;
        pick_idx   = hit_idx;
        if (!hit_any) begin
            if (free_any) begin
                pick_idx = free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                pick_idx = oldest_idx;
`else
                pick_valid = 1'b0;
`endif
            end
        end
    end

    // ------------------------------------------------------------------ FSM
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            cur_on       <= 1'b0;
            cur_note     <= '0;
            pick_valid_q <= 1'b0;
            pick_idx_q   <= '0;
            off_mask_q   <= '0;
            dropped      <= 1'b0;
        end else begin
            dropped <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_on    <= req_on;
                        cur_note  <= req_note;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    pick_valid_q <= pick_valid;
                    pick_idx_q   <= pick_idx;
                    off_mask_q   <= match_mask;
                    state        <= COMMIT;
                end
                COMMIT: begin
                    dropped   <= cur_on && !pick_valid_q;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------- voice update
    logic [NVOICES-1:0]  en_nxt;
    logic [NOTE_W-1:0]   note_nxt   [NVOICES];
    logic [PERIOD_W-1:0] period_nxt [NVOICES];
    logic [AGE_W-1:0]    age_nxt    [NVOICES];

    always_comb begin
        en_nxt     = en_q;
        note_nxt   = note_q;
        period_nxt = period_q;
        age_nxt    = age_q;
        if (state == COMMIT) begin
            if (cur_on) begin
                if (pick_valid_q) begin
                    for (int i = 0; i < NVOICES; i++) begin
                        if (idx_t'(i) == pick_idx_q) begin
                            en_nxt[i]     = 1'b1;
                            note_nxt[i]   = cur_note;
                            period_nxt[i] = rom_data;
                            age_nxt[i]    = '0;
                        end else if (en_q[i] && (age_q[i] != '1)) begin
                            age_nxt[i] = age_q[i] + AGE_W'(1);
                        end
                    end
                end
            end else begin
                // Note-off keeps the period so a released voice holds its pitch.
                en_nxt = en_q & ~off_mask_q;
            end
        end
    end

    function automatic logic [3:0] popcount(input logic [NVOICES-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NVOICES; i++) c = c + 4'(v[i]);
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= '0;
            active_count <= '0;
            for (int i = 0; i < NVOICES; i++) begin
                note_q[i]   <= '0;
                period_q[i] <= '0;
                age_q[i]    <= '0;
            end
        end else begin
            en_q         <= en_nxt;
            active_count <= popcount(en_nxt);
            note_q       <= note_nxt;
            period_q     <= period_nxt;
            age_q        <= age_nxt;
        end
    end

    assign voice_en = en_q;

    for (genvar i = 0; i < NVOICES; i++) begin : g_pack
        assign voice_period[i*PERIOD_W +: PERIOD_W] = period_q[i];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
// Self-checking bench for voice_allocator. A behavioural model tracks the
// voice bank as plain arrays, derives periods from the pitch formula in real
// arithmetic, and expresses voice age as "note-on commits since assignment".
// One process compares every DUT output against the model on each falling
// edge; directed sequences add hand-computed literal expectations.
// Honours VOICE_STEAL_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_voice_allocator;

    localparam int NV      = 4;
    localparam int AGE_W   = 8;
    localparam int AGE_MAX = (1 << AGE_W) - 1;
    localparam int PW      = 26;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic               req_on;
    logic [6:0]         req_note;
    logic [NV-1:0]      voice_en;
    logic [NV*PW-1:0]   voice_period;
    logic [3:0]         active_count;
    logic               dropped;

    voice_allocator #(.NVOICES(NV), .AGE_W(AGE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_on       (req_on),
        .req_note     (req_note),
        .voice_en     (voice_en),
        .voice_period (voice_period),
        .active_count (active_count),
        .dropped      (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    bit m_en     [NV];
    int m_note   [NV];
    int m_period [NV];
    int m_stamp  [NV];
    int m_on_count;
    int m_busy;
    bit m_ready;
    bit m_dropped;
    bit p_on;
    int p_note;

    function automatic int model_period(input int n);
        real p;
        p = 48.0e6 / 440.0 * (2.0 ** ((69.0 - real'(n)) / 12.0));
        return int'(p);
    endfunction

    function automatic int model_age(input int v);
        int a;
        a = m_on_count - m_stamp[v];
        return (a > AGE_MAX) ? AGE_MAX : a;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_en[i] = 0; m_note[i] = 0; m_period[i] = 0; m_stamp[i] = 0;
        end
        m_on_count = 0;
        m_busy     = 0;
        m_ready    = 1;
        m_dropped  = 0;
    endfunction

    function automatic void model_commit();
        int v;
        int best;
        v    = -1;
        best = -1;
        if (p_on) begin
            for (int i = 0; i < NV; i++) if (v < 0 && m_en[i] && m_note[i] == p_note) v = i;
            for (int i = 0; i < NV; i++) if (v < 0 && !m_en[i]) v = i;
`ifdef VOICE_STEAL_EN
            if (v < 0) begin
                for (int i = 0; i < NV; i++) begin
                    if (model_age(i) > best) begin
                        best = model_age(i);
                        v    = i;
                    end
                end
            end
`endif
            if (v < 0) begin
                m_dropped = 1;
            end else begin
                m_on_count++;
                m_en[v]     = 1;
                m_note[v]   = p_note;
                m_period[v] = model_period(p_note);
                m_stamp[v]  = m_on_count;
            end
        end else begin
            for (int i = 0; i < NV; i++) if (m_en[i] && m_note[i] == p_note) m_en[i] = 0;
        end
    endfunction

    // Handshake-level timing: accept, two busy edges, commit on the third.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_dropped = 0;
                if (m_busy == 0) begin
                    if (req_valid) begin
                        p_on    = req_on;
                        p_note  = int'(req_note);
                        m_busy  = 2;
                        m_ready = 0;
                    end
                end else begin
                    m_busy--;
                    if (m_busy == 0) begin
                        model_commit();
                        m_ready = 1;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- compare
    initial begin
        forever begin
            logic [NV-1:0] e;
            int cnt;
            @(negedge clk);
            e   = '0;
            cnt = 0;
            for (int i = 0; i < NV; i++) begin
                e[i] = m_en[i];
                cnt += int'(m_en[i]);
            end
            check("voice_en", 64'(voice_en), 64'(e));
            for (int i = 0; i < NV; i++)
                check($sformatf("period[%0d]", i), 64'(voice_period[i*PW +: PW]), 64'(m_period[i]));
            check("active_count", 64'(active_count), 64'(cnt));
            check("dropped", 64'(dropped), 64'(m_dropped));
            check("req_ready", 64'(req_ready), 64'(m_ready));
        end
    end

    // ---------------------------------------------------------------- drivers
    function automatic logic [PW-1:0] per(input int v);
        return voice_period[v*PW +: PW];
    endfunction

    // Called on a falling edge; returns on the falling edge after the commit
    // edge. Junk is driven on req_valid while the DUT is busy.
    task automatic send(input bit on, input int note);
        int guard;
        guard     = 0;
        req_valid = 1'b1;
        req_on    = on;
        req_note  = 7'(note);
        while (req_ready !== 1'b1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 16) begin
            check("ready_timeout", 64'(req_ready), 64'(1));
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'($urandom_range(0, 1));
        req_on    = 1'($urandom_range(0, 1));
        req_note  = 7'($urandom_range(0, 127));
        @(negedge clk);
        req_valid = 1'($urandom_range(0, 1));
        req_note  = 7'($urandom_range(0, 127));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int pool [8] = '{0, 127, 48, 60, 64, 67, 69, 72};

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_on    = 1'b0;
        req_note  = '0;

        // Model pins against hand-computed periods.
        check("model_period(69)", 64'(model_period(69)), 64'(109091));
        check("model_period(0)",  64'(model_period(0)),  64'(5870986));
        check("model_period(48)", 64'(model_period(48)), 64'(366937));

        @(negedge clk);
        check("reset voice_en", 64'(voice_en), 64'(0));
        check("reset period", 64'(voice_period), 64'(0));
        check("reset ready", 64'(req_ready), 64'(1));
        do_reset();

        // First note lands in voice 0.
        send(1, 69);
        check("on69 en", 64'(voice_en), 64'(4'b0001));
        check("on69 p0", 64'(per(0)), 64'(109091));
        check("on69 count", 64'(active_count), 64'(1));
        check("on69 ready", 64'(req_ready), 64'(1));

        send(1, 60);
        send(1, 64);
        send(1, 67);
        check("fill en", 64'(voice_en), 64'(4'b1111));
        check("fill p1", 64'(per(1)), 64'(183468));
        check("fill p2", 64'(per(2)), 64'(145619));
        check("fill p3", 64'(per(3)), 64'(122450));
        check("fill count", 64'(active_count), 64'(4));

        send(0, 64);
        check("off64 en", 64'(voice_en), 64'(4'b1011));
        check("off64 p2 kept", 64'(per(2)), 64'(145619));
        check("off64 count", 64'(active_count), 64'(3));

        send(1, 72);
        check("on72 en", 64'(voice_en), 64'(4'b1111));
        check("on72 p2", 64'(per(2)), 64'(91734));

        // Full bank 69, 60, 64, 67; voice 0 is the oldest.
        do_reset();
        send(1, 69);
        send(1, 60);
        send(1, 64);
        send(1, 67);
        send(1, 48);
`ifdef VOICE_STEAL_EN
        check("steal dropped", 64'(dropped), 64'(0));
        check("steal p0", 64'(per(0)), 64'(366937));
        check("steal en", 64'(voice_en), 64'(4'b1111));
`else
        check("full dropped", 64'(dropped), 64'(1));
        check("full p0", 64'(per(0)), 64'(109091));
        check("full en", 64'(voice_en), 64'(4'b1111));
        @(negedge clk);
        check("full dropped one cycle", 64'(dropped), 64'(0));
`endif

        // Retrigger an active note; then release a note nobody plays.
        send(1, 60);
        check("retrig en", 64'(voice_en), 64'(4'b1111));
        check("retrig p1", 64'(per(1)), 64'(183468));
        check("retrig count", 64'(active_count), 64'(4));
        check("retrig dropped", 64'(dropped), 64'(0));
        send(0, 100);
        check("off100 en", 64'(voice_en), 64'(4'b1111));
        check("off100 dropped", 64'(dropped), 64'(0));

        // Reset during LOOKUP.
        req_valid = 1'b1;
        req_on    = 1'b1;
        req_note  = 7'(50);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("midrst en", 64'(voice_en), 64'(0));
        check("midrst period", 64'(voice_period), 64'(0));
        check("midrst count", 64'(active_count), 64'(0));
        check("midrst dropped", 64'(dropped), 64'(0));
        check("midrst ready", 64'(req_ready), 64'(1));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(1, 69);
        check("post-rst en", 64'(voice_en), 64'(4'b0001));
        check("post-rst p0", 64'(per(0)), 64'(109091));
        check("post-rst count", 64'(active_count), 64'(1));

        // Randomised traffic: small note pool so matches and full banks recur.
        for (int n = 0; n < 400; n++) begin
            int note;
            bit on;
            on   = ($urandom_range(0, 99) < 60);
            note = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127))
                                               : pool[$urandom_range(0, 7)];
            send(on, note);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
